// File: rtl/audio_ctrl_sequencer.sv
// Pop-free control front end for the audio mixer: owns attenuation, mix, filter
// select and mute, and fades every filter switch or pause through a hard mute.
module audio_ctrl_sequencer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          RAMP_SAMPLES   = 4,
    parameter int          SETTLE_SAMPLES = 64,
    parameter logic [3:0]  VOL_DEFAULT    = 4'd0,
    parameter logic [1:0]  MIX_DEFAULT    = 2'd0,
    parameter logic [3:0]  FILTER_DEFAULT = 4'd0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        sample_ce,
    input  logic        pause_core,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    output logic [3:0]  vol_att,
    output logic [1:0]  mix,
    output logic [3:0]  afilter_sw,
    output logic        mute,
    output logic        busy
);

    // state    | meaning
    // IDLE     | vol_att at target, nothing pending
    // RAMP     | stepping vol_att toward vol_tgt (also the fade-in after mute)
    // FADE_OUT | stepping vol_att up to 15 ahead of a mute
    // MUTED    | hard mute; apply pending filter or release when unpaused
    // SETTLE   | hold mute for SETTLE_SAMPLES strobes after a filter change
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_FADE_OUT = 3'd2,
        ST_MUTED    = 3'd3,
        ST_SETTLE   = 3'd4
    } state_t;

    localparam int STEP_W = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
    localparam int SET_W  = $clog2(SETTLE_SAMPLES + 1);

    state_t            state_q;
    logic [3:0]        vol_att_q;
    logic [3:0]        vol_tgt_q;
    logic              mute_q;
    logic [1:0]        mix_q;
    logic [3:0]        afilter_q;
    logic [3:0]        filt_tgt_q;
    logic              filt_pend_q;
    logic [STEP_W-1:0] step_q;
    logic [SET_W-1:0]  settle_q;
    logic [31:0]       rd_data_q;
    logic [31:0]       rd_data_d;

    logic sel_vol, sel_mix, sel_filt, sel_stat;
    logic wr_vol, wr_mix, wr_filt;
    logic stepping, step_tick;
    logic unused_wr_bits;

    assign sel_vol  = (bridge_addr == BASE_ADDR);
    assign sel_mix  = (bridge_addr == BASE_ADDR + 32'h4);
    assign sel_filt = (bridge_addr == BASE_ADDR + 32'h8);
    assign sel_stat = (bridge_addr == BASE_ADDR + 32'hC);

    assign wr_vol  = bridge_wr && sel_vol;
    assign wr_mix  = bridge_wr && sel_mix;
    assign wr_filt = bridge_wr && sel_filt;

    assign unused_wr_bits = ^bridge_wr_data[31:4];

    assign stepping  = (state_q == ST_RAMP) || (state_q == ST_FADE_OUT);
    assign step_tick = stepping && sample_ce && (step_q == STEP_W'(RAMP_SAMPLES - 1));

    always_comb begin
        rd_data_d = '0;
        if (sel_vol) begin
            rd_data_d[3:0] = vol_tgt_q;
        end else if (sel_mix) begin
            rd_data_d[1:0] = mix_q;
        end else if (sel_filt) begin
            rd_data_d[3:0] = filt_tgt_q;
        end else if (sel_stat) begin
            rd_data_d[2:0] = state_q;
            rd_data_d[7:4] = vol_att_q;
            rd_data_d[8]   = mute_q;
            rd_data_d[9]   = filt_pend_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_MUTED;
            vol_att_q   <= 4'd15;
            vol_tgt_q   <= VOL_DEFAULT;
            mute_q      <= 1'b1;
            mix_q       <= MIX_DEFAULT;
            afilter_q   <= FILTER_DEFAULT;
            filt_tgt_q  <= FILTER_DEFAULT;
            filt_pend_q <= 1'b0;
            step_q      <= '0;
            settle_q    <= '0;
            rd_data_q   <= '0;
        end else begin
            if (stepping && sample_ce) begin
                step_q <= step_tick ? '0 : step_q + 1'b1;
            end
            if (wr_vol) begin
                vol_tgt_q <= bridge_wr_data[3:0];
            end
            if (wr_mix) begin
                mix_q <= bridge_wr_data[1:0];
            end
            if (bridge_rd) begin
                rd_data_q <= rd_data_d;
            end

            // Every transition below also clears the step counter.
            case (state_q)
                ST_IDLE: begin
                    if (pause_core || filt_pend_q) begin
                        state_q <= ST_FADE_OUT;
                        step_q  <= '0;
                    end else if (vol_att_q != vol_tgt_q) begin
                        state_q <= ST_RAMP;
                        step_q  <= '0;
                    end
                end
                ST_RAMP: begin
                    if (pause_core || filt_pend_q) begin
                        state_q <= ST_FADE_OUT;
                        step_q  <= '0;
                    end else if (vol_att_q == vol_tgt_q) begin
                        state_q <= ST_IDLE;
                        step_q  <= '0;
                    end else if (step_tick) begin
                        vol_att_q <= (vol_att_q < vol_tgt_q) ? vol_att_q + 4'd1
                                                             : vol_att_q - 4'd1;
                    end
                end
                ST_FADE_OUT: begin
                    if (vol_att_q == 4'd15) begin
                        mute_q  <= 1'b1;
                        state_q <= ST_MUTED;
                        step_q  <= '0;
                    end else if (step_tick) begin
                        vol_att_q <= vol_att_q + 4'd1;
                    end
                end
                ST_MUTED: begin
                    if (filt_pend_q) begin
                        afilter_q   <= filt_tgt_q;
                        filt_pend_q <= 1'b0;
                        settle_q    <= SET_W'(SETTLE_SAMPLES);
                        state_q     <= ST_SETTLE;
                        step_q      <= '0;
                    end else if (!pause_core) begin
                        mute_q  <= 1'b0;
                        state_q <= ST_RAMP;
                        step_q  <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= ST_MUTED;
                        step_q  <= '0;
                    end else if (sample_ce) begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    step_q  <= '0;
                end
            endcase

            // Placed after the FSM so a write landing on the consume cycle wins.
            if (wr_filt) begin
                filt_tgt_q <= bridge_wr_data[3:0];
                if (!((bridge_wr_data[3:0] == afilter_q) && !filt_pend_q)) begin
                    filt_pend_q <= 1'b1;
                end
            end
        end
    end

    assign bridge_rd_data = rd_data_q;
    assign vol_att        = vol_att_q;
    assign mix            = mix_q;
    assign afilter_sw     = afilter_q;
    assign mute           = mute_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_audio_ctrl_sequencer.sv
// Directed bench for audio_ctrl_sequencer: ramps, pause fades, filter switch
// sequencing, reset recovery and a table of register accesses.
module tb_audio_ctrl_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        sample_ce;
    logic        pause_core;
    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;
    logic [3:0]  vol_att;
    logic [1:0]  mix;
    logic [3:0]  afilter_sw;
    logic        mute;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    audio_ctrl_sequencer #(
        .BASE_ADDR      (32'h0000_0000),
        .RAMP_SAMPLES   (4),
        .SETTLE_SAMPLES (8),
        .VOL_DEFAULT    (4'd0),
        .MIX_DEFAULT    (2'd0),
        .FILTER_DEFAULT (4'd0)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .sample_ce      (sample_ce),
        .pause_core     (pause_core),
        .bridge_addr    (bridge_addr),
        .bridge_wr      (bridge_wr),
        .bridge_wr_data (bridge_wr_data),
        .bridge_rd      (bridge_rd),
        .bridge_rd_data (bridge_rd_data),
        .vol_att        (vol_att),
        .mix            (mix),
        .afilter_sw     (afilter_sw),
        .mute           (mute),
        .busy           (busy)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_mix;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe();
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bridge_addr    = a;
        bridge_wr_data = d;
        bridge_wr      = 1'b1;
        tick();
        bridge_wr = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [31:0] a);
        bridge_addr = a;
        bridge_rd   = 1'b1;
        tick();
        bridge_rd = 1'b0;
    endtask

    // vol_att expected to move one step every 4 strobes starting from a fresh counter.
    task automatic run_ramp(input int n, input int start, input int dir, input string name);
        for (int i = 1; i <= n; i++) begin
            strobe();
            chk($sformatf("%s_s%0d", name, i), {28'd0, vol_att}, 32'(start + dir * (i / 4)));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'h0000_01F3, 2'd0};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFF2, 1'b0, 32'h0,         2'd2};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h0000_0002, 2'd2};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'h0000_0037, 1'b0, 32'h0,         2'd2};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0007, 2'd2};
        vecs[5]  = '{1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'h0,         2'd2};
        vecs[6]  = '{1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'h0000_01F3, 2'd2};
        vecs[7]  = '{1'b1, 32'h0000_0008, 32'h0000_0009, 1'b0, 32'h0,         2'd2};
        vecs[8]  = '{1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'h0000_03F3, 2'd2};
        vecs[9]  = '{1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'h0000_01F4, 2'd2};
        vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h0000_0009, 2'd2};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0000, 2'd2};
        vecs[12] = '{1'b0, 32'h1000_0004, 32'h0,         1'b1, 32'h0000_0000, 2'd2};
        vecs[13] = '{1'b1, 32'h1000_0004, 32'h0000_0001, 1'b0, 32'h0,         2'd2};
        vecs[14] = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h0000_0002, 2'd2};

        reset          = 1'b1;
        sample_ce      = 1'b0;
        pause_core     = 1'b0;
        bridge_addr    = '0;
        bridge_wr      = 1'b0;
        bridge_wr_data = '0;
        bridge_rd      = 1'b0;
        repeat (3) tick();

        chk("rst_vol", {28'd0, vol_att}, 32'd15);
        chk("rst_mute", {31'd0, mute}, 32'd1);
        chk("rst_mix", {30'd0, mix}, 32'd0);
        chk("rst_filter", {28'd0, afilter_sw}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_rd_data", bridge_rd_data, 32'd0);

        reset = 1'b0;
        tick();
        chk("release_mute", {31'd0, mute}, 32'd0);
        chk("release_vol", {28'd0, vol_att}, 32'd15);
        run_ramp(60, 15, -1, "init_fadein");
        chk("init_idle", {31'd0, busy}, 32'd0);

        wr(32'h0, 32'd6);
        run_ramp(24, 0, 1, "up6");
        chk("up6_idle", {31'd0, busy}, 32'd0);
        wr(32'h0, 32'd0);
        run_ramp(24, 6, -1, "down0");
        wr(32'h0, 32'd6);
        run_ramp(20, 0, 1, "up5");
        wr(32'h0, 32'd3);
        run_ramp(8, 5, -1, "retarget3");
        chk("retarget_idle", {31'd0, busy}, 32'd0);
        wr(32'h0, 32'd2);
        run_ramp(4, 3, -1, "to2");

        pause_core = 1'b1;
        tick();
        chk("pause_busy", {31'd0, busy}, 32'd1);
        run_ramp(52, 2, 1, "pause_fade");
        chk("pause_mute", {31'd0, mute}, 32'd1);
        pause_core = 1'b0;
        tick();
        chk("unpause_mute", {31'd0, mute}, 32'd0);
        run_ramp(52, 15, -1, "unpause_fadein");
        chk("unpause_idle", {31'd0, busy}, 32'd0);

        wr(32'h8, 32'd3);
        chk("filt_pre_sw", {28'd0, afilter_sw}, 32'd0);
        chk("filt_pre_mute", {31'd0, mute}, 32'd0);
        run_ramp(52, 2, 1, "filt_fade");
        chk("filt_mute", {31'd0, mute}, 32'd1);
        chk("filt_not_yet", {28'd0, afilter_sw}, 32'd0);
        tick();
        chk("filt_switched", {28'd0, afilter_sw}, 32'd3);
        for (int i = 1; i <= 8; i++) begin
            strobe();
            chk($sformatf("settle_mute_s%0d", i), {31'd0, mute}, 32'd1);
        end
        tick();
        chk("settle_release", {31'd0, mute}, 32'd0);
        chk("settle_keep_sw", {28'd0, afilter_sw}, 32'd3);
        run_ramp(52, 15, -1, "filt_fadein");
        chk("filt_idle", {31'd0, busy}, 32'd0);
        wr(32'h8, 32'd3);
        repeat (3) begin
            tick();
            chk("same_filt_busy", {31'd0, busy}, 32'd0);
        end
        rd(32'hC);
        chk("same_filt_status", bridge_rd_data, 32'h0000_0020);

        pause_core = 1'b1;
        wr(32'h8, 32'd5);
        chk("combo_busy", {31'd0, busy}, 32'd1);
        run_ramp(52, 2, 1, "combo_fade");
        chk("combo_mute", {31'd0, mute}, 32'd1);
        tick();
        chk("combo_sw", {28'd0, afilter_sw}, 32'd5);
        repeat (8) strobe();
        repeat (3) begin
            tick();
            chk("combo_hold_mute", {31'd0, mute}, 32'd1);
            chk("combo_hold_busy", {31'd0, busy}, 32'd1);
        end
        rd(32'hC);
        chk("combo_status", bridge_rd_data, 32'h0000_01F3);

        pause_core = 1'b0;
        tick();
        run_ramp(8, 15, -1, "pre_reset_fadein");
        pause_core = 1'b1;
        tick();
        run_ramp(4, 13, 1, "pre_reset_fade");
        reset = 1'b1;
        tick();
        chk("midrst_vol", {28'd0, vol_att}, 32'd15);
        chk("midrst_mute", {31'd0, mute}, 32'd1);
        chk("midrst_filter", {28'd0, afilter_sw}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_rd_data", bridge_rd_data, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            bridge_addr = vecs[i].addr;
            if (vecs[i].wr) begin
                bridge_wr_data = vecs[i].data;
                bridge_wr      = 1'b1;
            end else begin
                bridge_rd = 1'b1;
            end
            tick();
            bridge_wr = 1'b0;
            bridge_rd = 1'b0;
            if (vecs[i].chk_rd) begin
                chk($sformatf("vec%0d_rd", i), bridge_rd_data, vecs[i].exp_rd);
            end
            chk($sformatf("vec%0d_mix", i), {30'd0, mix}, {30'd0, vecs[i].exp_mix});
        end
        chk("tbl_filter", {28'd0, afilter_sw}, 32'd9);
        chk("tbl_mute", {31'd0, mute}, 32'd1);

        pause_core = 1'b0;
        repeat (8) strobe();
        tick();
        chk("tbl_release", {31'd0, mute}, 32'd0);
        run_ramp(32, 15, -1, "tbl_fadein");
        chk("tbl_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
